// File: rtl/bp_pkg.sv
// Shared definitions for the branch-predictor update stage: kind encoding,
// PC width, the resolved-branch record and the 2-bit counter step.
package bp_pkg;

  localparam int PC_W = 30;

  // Kind value that marks a record as "not a control transfer".
  localparam logic [2:0] KIND_NONE = 3'd0;

  // One resolved-branch record as it travels from S0 into S1.
  typedef struct packed {
    logic            taken_pdc;
    logic [2:0]      kind_pdc;
    logic [PC_W-1:0] npc_pdc;
    logic            taken_ex;
    logic [2:0]      kind_ex;
    logic [PC_W-1:0] npc_ex;
    logic [PC_W-1:0] pc;
  } bp_rec_t;

  // Saturating 2-bit counter step: up on taken, down on not taken.
  function automatic logic [1:0] sat_ctr2_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_update_unit_if.sv
// Bundle of the record input, PHT/BTB write ports and statistics outputs.
// slave = the update unit, master = the resolution buffer / RAM side.
interface bp_update_unit_if
  import bp_pkg::*;
#(
  parameter int PHT_IDX = 10,
  parameter int BTB_IDX = 8
);

  logic                    update_en;
  logic                    taken_pdc;
  logic [2:0]              kind_pdc;
  logic [PC_W-1:0]         npc_pdc;
  logic                    taken_ex;
  logic [2:0]              kind_ex;
  logic [PC_W-1:0]         npc_ex;
  logic [PC_W-1:0]         pc_ex;

  logic [PHT_IDX-1:0]      pht_ridx;
  logic [1:0]              pht_rdata;
  logic                    pht_we;
  logic [PHT_IDX-1:0]      pht_widx;
  logic [1:0]              pht_wdata;

  logic                    btb_we;
  logic [BTB_IDX-1:0]      btb_widx;
  logic [PC_W-BTB_IDX-1:0] btb_wtag;
  logic [PC_W-1:0]         btb_wtarget;
  logic [2:0]              btb_wkind;

  logic                    mispredict;
  logic [31:0]             cnt_update;
  logic [31:0]             cnt_mispredict;

  modport slave (
    input  update_en, taken_pdc, kind_pdc, npc_pdc, taken_ex, kind_ex, npc_ex, pc_ex,
    input  pht_rdata,
    output pht_ridx, pht_we, pht_widx, pht_wdata,
    output btb_we, btb_widx, btb_wtag, btb_wtarget, btb_wkind,
    output mispredict, cnt_update, cnt_mispredict
  );

  modport master (
    output update_en, taken_pdc, kind_pdc, npc_pdc, taken_ex, kind_ex, npc_ex, pc_ex,
    output pht_rdata,
    input  pht_ridx, pht_we, pht_widx, pht_wdata,
    input  btb_we, btb_widx, btb_wtag, btb_wtarget, btb_wkind,
    input  mispredict, cnt_update, cnt_mispredict
  );

endinterface

// File: rtl/bp_update_unit_sat_ctr2.sv
// Combinational next-state of a 2-bit saturating PHT counter.
module sat_ctr2
  import bp_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr
);

  assign o_ctr = sat_ctr2_step(i_ctr, i_taken);

endmodule

// File: rtl/bp_update_unit.sv
// Predictor update stage: S0 issues the PHT read, S1 classifies the record,
// writes the PHT counter (with write-to-read forwarding) and the BTB entry,
// and keeps saturating update / mispredict statistics.
module bp_update_unit
  import bp_pkg::*;
#(
  parameter int PHT_IDX = 10,
  parameter int BTB_IDX = 8
)(
  input  logic             clk,
  input  logic             rstn,
  bp_update_unit_if.slave  bus
);

  bp_rec_t            w_rec_in;
  bp_rec_t            r_s1_rec;
  logic               r_s1_valid;

  logic               r_fwd_valid;
  logic [PHT_IDX-1:0] r_fwd_idx;
  logic [1:0]         r_fwd_data;

  logic [31:0]        r_cnt_update;
  logic [31:0]        r_cnt_mispredict;

  logic [PHT_IDX-1:0] w_s1_idx;
  logic               w_fwd_hit;
  logic [1:0]         w_ctr;
  logic [1:0]         w_ctr_next;
  logic               w_is_branch;
  logic               w_miss;
  logic               w_pht_we;

  assign w_rec_in = '{
    taken_pdc: bus.taken_pdc, kind_pdc: bus.kind_pdc, npc_pdc: bus.npc_pdc,
    taken_ex:  bus.taken_ex,  kind_ex:  bus.kind_ex,  npc_ex:  bus.npc_ex,
    pc:        bus.pc_ex
  };

  // S0: synchronous PHT read is launched straight from the incoming PC.
  assign bus.pht_ridx = bus.pc_ex[PHT_IDX-1:0];

  // S1 pipeline register; a reset drops whatever record is in flight.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_rec   <= '0;
    end else begin
      r_s1_valid <= bus.update_en;
      r_s1_rec   <= w_rec_in;
    end
  end

  // The RAM returns stale data when the previous S1 wrote the index now in S1,
  // so the last written value overrides it.
  assign w_s1_idx  = r_s1_rec.pc[PHT_IDX-1:0];
  assign w_fwd_hit = r_fwd_valid && (r_fwd_idx == w_s1_idx);
  assign w_ctr     = w_fwd_hit ? r_fwd_data : bus.pht_rdata;

  sat_ctr2 u_sat_ctr2 (
    .i_ctr   (w_ctr),
    .i_taken (r_s1_rec.taken_ex),
    .o_ctr   (w_ctr_next)
  );

  assign w_is_branch = (r_s1_rec.kind_ex != KIND_NONE);
  assign w_miss      = (r_s1_rec.taken_pdc != r_s1_rec.taken_ex)
                     | (r_s1_rec.kind_pdc  != r_s1_rec.kind_ex)
                     | (r_s1_rec.taken_ex  && (r_s1_rec.npc_pdc != r_s1_rec.npc_ex));
  assign w_pht_we    = r_s1_valid && w_is_branch;

  assign bus.pht_we      = w_pht_we;
  assign bus.pht_widx    = w_s1_idx;
  assign bus.pht_wdata   = r_s1_valid ? w_ctr_next : 2'b00;

  // BTB is only refreshed by a taken branch whose prediction was wrong.
  assign bus.btb_we      = r_s1_valid && r_s1_rec.taken_ex && w_is_branch && w_miss;
  assign bus.btb_widx    = r_s1_rec.pc[BTB_IDX-1:0];
  assign bus.btb_wtag    = r_s1_rec.pc[PC_W-1:BTB_IDX];
  assign bus.btb_wtarget = r_s1_rec.npc_ex;
  assign bus.btb_wkind   = r_s1_rec.kind_ex;

  assign bus.mispredict  = r_s1_valid && w_miss;

  // Forward register remembers the last PHT write; bubbles leave it untouched.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fwd_valid <= 1'b0;
      r_fwd_idx   <= '0;
      r_fwd_data  <= 2'b00;
    end else if (w_pht_we) begin
      r_fwd_valid <= 1'b1;
      r_fwd_idx   <= w_s1_idx;
      r_fwd_data  <= w_ctr_next;
    end
  end

  // Statistics counters, each holding once it reaches all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt_update     <= '0;
      r_cnt_mispredict <= '0;
    end else begin
      if (r_s1_valid && (r_cnt_update != '1))
        r_cnt_update <= r_cnt_update + 32'd1;
      if (r_s1_valid && w_miss && (r_cnt_mispredict != '1))
        r_cnt_mispredict <= r_cnt_mispredict + 32'd1;
    end
  end

  assign bus.cnt_update     = r_cnt_update;
  assign bus.cnt_mispredict = r_cnt_mispredict;

endmodule

// File: tb/tb_bp_update_unit.sv
// Directed bench for bp_update_unit: a table of isolated records plus
// hand-written reset, forwarding-hazard and bubble sequences.
module tb_bp_update_unit;
  import bp_pkg::*;

  localparam int PHT_IDX = 10;
  localparam int BTB_IDX = 8;

  logic clk;
  logic rstn;

  bp_update_unit_if #(.PHT_IDX(PHT_IDX), .BTB_IDX(BTB_IDX)) bus ();

  bp_update_unit #(.PHT_IDX(PHT_IDX), .BTB_IDX(BTB_IDX)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_upd  = 0;
  int exp_mis  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        taken_pdc;
    logic [2:0]  kind_pdc;
    logic [29:0] npc_pdc;
    logic        taken_ex;
    logic [2:0]  kind_ex;
    logic [29:0] npc_ex;
    logic [29:0] pc;
    logic [1:0]  rdata;
    logic        exp_pht_we;
    logic [1:0]  exp_wdata;
    logic        exp_btb_we;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[10];

  task automatic drive_rec(input vec_t v);
    bus.taken_pdc = v.taken_pdc;
    bus.kind_pdc  = v.kind_pdc;
    bus.npc_pdc   = v.npc_pdc;
    bus.taken_ex  = v.taken_ex;
    bus.kind_ex   = v.kind_ex;
    bus.npc_ex    = v.npc_ex;
    bus.pc_ex     = v.pc;
  endtask

  initial begin
    vec_t rec;
    logic [29:0] pc;

    //          tpdc kpdc npc_pdc   tex kex npc_ex    pc        rd     pwe wd     bwe mis
    vecs[0] = '{1'b1, 3'd1, 30'h200, 1'b1, 3'd1, 30'h200, 30'h100, 2'b01, 1'b1, 2'b10, 1'b0, 1'b0}; // correct taken
    vecs[1] = '{1'b1, 3'd1, 30'h300, 1'b1, 3'd1, 30'h200, 30'h104, 2'b10, 1'b1, 2'b11, 1'b1, 1'b1}; // target miss
    vecs[2] = '{1'b1, 3'd1, 30'h210, 1'b1, 3'd1, 30'h210, 30'h108, 2'b11, 1'b1, 2'b11, 1'b0, 1'b0}; // sat high
    vecs[3] = '{1'b0, 3'd1, 30'h10D, 1'b0, 3'd1, 30'h10D, 30'h10C, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0}; // sat low
    vecs[4] = '{1'b1, 3'd1, 30'h400, 1'b0, 3'd0, 30'h111, 30'h110, 2'b01, 1'b0, 2'b00, 1'b0, 1'b1}; // non-branch
    vecs[5] = '{1'b0, 3'd2, 30'h115, 1'b1, 3'd2, 30'h500, 30'h114, 2'b01, 1'b1, 2'b10, 1'b1, 1'b1}; // dir miss -> T
    vecs[6] = '{1'b1, 3'd2, 30'h600, 1'b0, 3'd2, 30'h119, 30'h118, 2'b10, 1'b1, 2'b01, 1'b0, 1'b1}; // dir miss -> NT
    vecs[7] = '{1'b0, 3'd1, 30'h700, 1'b0, 3'd1, 30'h11D, 30'h11C, 2'b10, 1'b1, 2'b01, 1'b0, 1'b0}; // NT, npc ignored
    vecs[8] = '{1'b1, 3'd1, 30'h800, 1'b1, 3'd3, 30'h800, 30'h120, 2'b01, 1'b1, 2'b10, 1'b1, 1'b1}; // kind miss
    vecs[9] = '{1'b0, 3'd4, 30'h2AAAA5C4, 1'b0, 3'd4, 30'h2AAAA5C4, 30'h2AAAA5C3, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0};

    rstn = 1'b0;
    bus.update_en = 1'b0;
    bus.pht_rdata = 2'b00;
    drive_rec(vecs[0]);

    // Reset state
    @(negedge clk);
    #1;
    check("rst_pht_we", 32'(bus.pht_we), 32'd0);
    check("rst_btb_we", 32'(bus.btb_we), 32'd0);
    check("rst_mispredict", 32'(bus.mispredict), 32'd0);
    check("rst_cnt_update", bus.cnt_update, 32'd0);
    check("rst_cnt_mispredict", bus.cnt_mispredict, 32'd0);
    check("rst_pht_ridx", 32'(bus.pht_ridx), 32'h100);
    rstn = 1'b1;

    // Table of isolated records: S0 cycle, then S1 cycle with RAM data
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_rec(vecs[i]);
      bus.update_en = 1'b1;
      pc = vecs[i].pc;
      #1;
      check($sformatf("v%0d_pht_ridx", i), 32'(bus.pht_ridx), 32'(pc[PHT_IDX-1:0]));
      @(negedge clk);
      bus.update_en = 1'b0;
      bus.pht_rdata = vecs[i].rdata;
      #1;
      check($sformatf("v%0d_pht_we", i), 32'(bus.pht_we), 32'(vecs[i].exp_pht_we));
      if (vecs[i].exp_pht_we) begin
        check($sformatf("v%0d_pht_widx", i), 32'(bus.pht_widx), 32'(pc[PHT_IDX-1:0]));
        check($sformatf("v%0d_pht_wdata", i), 32'(bus.pht_wdata), 32'(vecs[i].exp_wdata));
      end
      check($sformatf("v%0d_btb_we", i), 32'(bus.btb_we), 32'(vecs[i].exp_btb_we));
      if (vecs[i].exp_btb_we) begin
        check($sformatf("v%0d_btb_widx", i), 32'(bus.btb_widx), 32'(pc[BTB_IDX-1:0]));
        check($sformatf("v%0d_btb_wtag", i), 32'(bus.btb_wtag), 32'(pc[29:BTB_IDX]));
        check($sformatf("v%0d_btb_wtarget", i), 32'(bus.btb_wtarget), 32'(vecs[i].npc_ex));
        check($sformatf("v%0d_btb_wkind", i), 32'(bus.btb_wkind), 32'(vecs[i].kind_ex));
      end
      check($sformatf("v%0d_mispredict", i), 32'(bus.mispredict), 32'(vecs[i].exp_mis));
      exp_upd++;
      if (vecs[i].exp_mis) exp_mis++;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_cnt_update", i), bus.cnt_update, 32'(exp_upd));
      check($sformatf("v%0d_cnt_mispredict", i), bus.cnt_mispredict, 32'(exp_mis));
    end

    // Hazard: two back-to-back taken records at pc 0x40, RAM stays at 2'b00
    rec = '{1'b1, 3'd1, 30'h41, 1'b1, 3'd1, 30'h41, 30'h40, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0};
    @(negedge clk);
    drive_rec(rec);
    bus.update_en = 1'b1;
    @(negedge clk);
    bus.pht_rdata = 2'b00;
    #1;
    check("haz1_pht_we", 32'(bus.pht_we), 32'd1);
    check("haz1_pht_wdata", 32'(bus.pht_wdata), 32'd1);
    @(negedge clk);
    bus.update_en = 1'b0;
    bus.pht_rdata = 2'b00;
    #1;
    check("haz2_pht_we", 32'(bus.pht_we), 32'd1);
    check("haz2_pht_widx", 32'(bus.pht_widx), 32'h40);
    check("haz2_pht_wdata", 32'(bus.pht_wdata), 32'd2);
    exp_upd += 2;

    // Bubble: no writes, counters hold
    @(negedge clk);
    bus.pht_rdata = 2'b01;
    #1;
    check("bub_pht_we", 32'(bus.pht_we), 32'd0);
    check("bub_btb_we", 32'(bus.btb_we), 32'd0);
    check("bub_mispredict", 32'(bus.mispredict), 32'd0);
    @(posedge clk);
    #1;
    check("bub_cnt_update", bus.cnt_update, 32'(exp_upd));
    check("bub_cnt_mispredict", bus.cnt_mispredict, 32'(exp_mis));

    // Reset mid-stream drops the in-flight mispredicting record
    @(negedge clk);
    drive_rec(vecs[1]);
    bus.update_en = 1'b1;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("mrst_pht_we", 32'(bus.pht_we), 32'd0);
    check("mrst_btb_we", 32'(bus.btb_we), 32'd0);
    check("mrst_mispredict", 32'(bus.mispredict), 32'd0);
    check("mrst_pht_widx", 32'(bus.pht_widx), 32'd0);
    check("mrst_pht_wdata", 32'(bus.pht_wdata), 32'd0);
    check("mrst_btb_wtarget", 32'(bus.btb_wtarget), 32'd0);
    check("mrst_cnt_update", bus.cnt_update, 32'd0);
    check("mrst_cnt_mispredict", bus.cnt_mispredict, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rel_pht_we", 32'(bus.pht_we), 32'd0);
    check("rel_btb_we", 32'(bus.btb_we), 32'd0);
    @(negedge clk);
    bus.update_en = 1'b0;
    bus.pht_rdata = 2'b01;
    #1;
    check("rel2_pht_wdata", 32'(bus.pht_wdata), 32'd2);
    check("rel2_btb_we", 32'(bus.btb_we), 32'd1);
    @(posedge clk);
    #1;
    check("rel2_cnt_update", bus.cnt_update, 32'd1);
    check("rel2_cnt_mispredict", bus.cnt_mispredict, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_update_unit.md
# bp_update_unit

Predictor update stage directly downstream of the branch-resolution buffer. It consumes one resolved-branch record per cycle: the predicted and actual taken, kind and next-PC, plus the branch PC. It classifies each record as correct or mispredicted and does a pipelined read-modify-write of the 2-bit PHT counter. It also writes the BTB entry and keeps update and mispredict statistics.

## Interface
Parameters:
- PHT_IDX, 10: PHT index width. The PHT has 2^PHT_IDX 2-bit counters.
- BTB_IDX, 8: BTB index width. The BTB tag is 30-BTB_IDX bits.

Ports:
- clk  in  1  clock
- rstn  in  1  reset. Asynchronous, active-low.
- update_en  in  1  the record on the inputs is valid this cycle
- taken_pdc / kind_pdc / npc_pdc  in  1 / 3 / 30  predicted taken, kind and next-PC (word address)
- taken_ex / kind_ex / npc_ex  in  1 / 3 / 30  resolved taken, kind and next-PC
- pc_ex  in  30  branch PC (word address)
- pht_ridx  out  PHT_IDX  PHT read index. The RAM is synchronous; data returns on the next cycle.
- pht_rdata  in  2  PHT read data
- pht_we / pht_widx / pht_wdata  out  1 / PHT_IDX / 2  PHT write port
- btb_we / btb_widx / btb_wtag / btb_wtarget / btb_wkind  out  1 / BTB_IDX / 30-BTB_IDX / 30 / 3  BTB write port
- mispredict  out  1  registered; marks the S1 record as mispredicted
- cnt_update / cnt_mispredict  out  32 / 32  statistics counters; saturate at all-ones

## Operation
- Kind encoding: KIND_NONE=3'd0 means not a control transfer. Every other value is a branch class.
- Stage S0, the input cycle:
  - pht_ridx = pc_ex[PHT_IDX-1:0].
  - Register the record into S1 with s1_valid = update_en.
- Stage S1:
  - ctr = forwarded value when a hazard hits, otherwise pht_rdata.
  - miss = (taken_pdc≠taken_ex) | (kind_pdc≠kind_ex) | (taken_ex & npc_pdc≠npc_ex).
- PHT update: when s1_valid and kind_ex≠KIND_NONE, pht_we=1 and pht_widx = the S1 index.
  - pht_wdata = ctr+1 when taken, saturating at 2'b11.
  - pht_wdata = ctr-1 when not taken, saturating at 2'b00.
- BTB update:
  - btb_we=1 when s1_valid, taken_ex, kind_ex≠KIND_NONE and miss.
  - btb_widx = pc[BTB_IDX-1:0]; btb_wtag = pc[29:BTB_IDX]; btb_wtarget = npc_ex; btb_wkind = kind_ex.
- Records with kind_ex=KIND_NONE:
  - No PHT or BTB write.
  - Still counted in cnt_update.
  - miss still computed, so a falsely predicted branch on a non-branch counts as a mispredict.
- Forwarding: an S1 PHT write to index X while S0 reads X makes the RAM return stale data next cycle. A 1-entry register holds the last written index and data plus a valid bit. S1 uses the forwarded data when the last write index equals the current S1 index.
- Statistics: cnt_update increments on each s1_valid. cnt_mispredict increments on s1_valid & miss. Both hold at 32'hFFFF_FFFF.
- No backpressure. One record is accepted per cycle, unconditionally.

## Timing
- Latency: input record at cycle N gives PHT/BTB writes and mispredict on cycle N+1, combinational from S1 registers.
- Reset, asynchronous:
  - s1_valid=0 and forward valid=0.
  - pht_we=0, btb_we=0, mispredict=0.
  - cnt_update=0, cnt_mispredict=0.
  - All index, tag, target and data outputs 0.
  - pht_ridx follows pc_ex combinationally.
- Reset mid-operation drops the in-flight S1 record; no write occurs.
- Back-to-back records to the same index take the forwarded path. The second write equals the first write's value stepped once more.
- update_en=0 cycles create S1 bubbles: all write enables 0 and counters hold. A bubble clears nothing in the forward register, but the forward register only matches a record that is s1_valid.

## Structure
- Package bp_pkg: KIND_* constants, the PC width (30) and a saturating 2-bit counter function.
- Sub-module sat_ctr2: combinational next-counter computation from (ctr, taken).
- The top level holds the S1 register, the forward register, miss compare and the counters.

## Test plan
- Reset: rstn low mid-stream -> all write enables 0, counters 0, no write on the first cycle after release.
- Correct taken branch: pc=0x100, kind=1, pdc = ex, taken, npc=0x200, pht_rdata=2'b01 -> pht_wdata=2'b10, btb_we=0, mispredict=0.
- Target mispredict: pdc npc=0x300, ex npc=0x200, taken both -> btb_we=1, btb_wtarget=0x200, cnt_mispredict += 1.
- Saturation: pht_rdata=2'b11 and taken -> 2'b11; pht_rdata=2'b00 and not taken -> 2'b00.
- Hazard: two consecutive taken records at pc=0x40, RAM holding 2'b00 -> writes 2'b01 then 2'b10; the stale RAM read is ignored.
- Non-branch with kind_pdc=1, kind_ex=0 -> no PHT or BTB write, mispredict=1, cnt_update += 1.
